// File: rtl/control_store_loader.sv
// control_store_loader
//   Loads a 2**ADDR_W-word control store from a host over a valid/ready
//   word stream, then releases the program counter and serves control words
//   combinationally by fetch address.
//
//   Optional build macro: LOADER_CHECKSUM_EN
//     defined   - a 17th word is accepted after the program.
//                 It must equal the XOR of the 16 program words.
//                 A mismatch parks the block in ERROR with load_error set.
//     undefined - the 16th word goes straight to RUN; load_error is tied 0.
//
//   Ports
//     clk         rising-edge clock for all state
//     rst         synchronous active-high reset (clears memory too)
//     load_start  restart a program load; wins over a same-cycle transfer
//     wr_valid    host word valid
//     wr_data     host program/checksum word
//     wr_ready    block accepts a word this cycle (state decode only)
//     addr        fetch address from the program counter
//     prog        control word at addr in RUN, NOP (0) otherwise
//     cpu_hold    hold the program counter (low only in RUN)
//     load_done   single-cycle pulse on the first RUN cycle of each load
//     load_count  words accepted in the current load, 0..2**ADDR_W
//     load_error  checksum mismatch flag
//
//   state   | meaning
//   --------+--------------------------------------------------
//   S_IDLE  | out of reset, waiting for load_start
//   S_LOAD  | accepting program words into the store
//   S_CHECK | accepting the checksum word (checksum build only)
//   S_RUN   | store valid, CPU released
//   S_ERROR | checksum mismatch, CPU held until load_start/rst
module control_store_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] prog,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              load_error
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERROR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_ERROR} state_t;
`endif

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              done_q;
  logic              xfer;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] xor_q;
  logic [DATA_W-1:0] xor_d;
  logic              error_q;

  assign xor_d      = xor_q ^ wr_data;
  assign wr_ready   = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign load_error = error_q;
`else
  assign wr_ready   = (state_q == S_LOAD);
  assign load_error = 1'b0;
`endif

  assign xfer       = wr_valid & wr_ready;
  assign count_d    = count_q + (ADDR_W+1)'(1);
  assign cpu_hold   = (state_q != S_RUN);
  assign load_done  = done_q;
  assign load_count = count_q;
  assign prog       = (state_q == S_RUN) ? mem_q[addr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (load_start) begin
        // A restart drops whatever word is being offered this cycle.
        state_q <= S_LOAD;
        count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
        xor_q   <= '0;
        error_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_LOAD: begin
            if (xfer) begin
              mem_q[count_q[ADDR_W-1:0]] <= wr_data;
              count_q <= count_d;
`ifdef LOADER_CHECKSUM_EN
              xor_q <= xor_d;
`endif
              if (count_q == LAST_IDX) begin
`ifdef LOADER_CHECKSUM_EN
                state_q <= S_CHECK;
`else
                state_q <= S_RUN;
                done_q  <= 1'b1;
`endif
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_CHECK: begin
            if (xfer) begin
              if (wr_data == xor_q) begin
                state_q <= S_RUN;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_ERROR;
                error_q <= 1'b1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_store_loader.sv
module tb_control_store_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       wr_valid = 1'b0;
  logic [9:0] wr_data = '0;
  logic       wr_ready;
  logic [3:0] addr = '0;
  logic [9:0] prog;
  logic       cpu_hold;
  logic       load_done;
  logic [4:0] load_count;
  logic       load_error;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  control_store_loader #(.ADDR_W(4), .DATA_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .addr       (addr),
    .prog       (prog),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_count (load_count),
    .load_error (load_error)
  );

  // Reference model: a load is a list of accepted words; the store only
  // becomes visible once a complete (and, if enabled, verified) load ends.
  localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_RUN = 3, P_ERROR = 4;
  int         m_phase = P_IDLE;
  logic [9:0] m_words[$];
  logic [9:0] m_mem[16];
  bit         m_done = 1'b0;
  bit         m_err = 1'b0;

  function automatic logic [9:0] words_xor();
    logic [9:0] x = '0;
    foreach (m_words[i]) x ^= m_words[i];
    return x;
  endfunction

  task automatic finish_load();
    for (int i = 0; i < 16; i++) m_mem[i] = m_words[i];
    m_phase = P_RUN;
    m_done  = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_IDLE;
      m_words.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
    end else begin
      m_done = 1'b0;
      if (load_start) begin
        m_phase = P_LOAD;
        m_words.delete();
        m_err = 1'b0;
      end else if (wr_valid && m_phase == P_LOAD) begin
        m_words.push_back(wr_data);
        if (m_words.size() == 16) begin
`ifdef LOADER_CHECKSUM_EN
          m_phase = P_CHECK;
`else
          finish_load();
`endif
        end
      end else if (wr_valid && m_phase == P_CHECK) begin
        if (wr_data == words_xor()) finish_load();
        else begin
          m_phase = P_ERROR;
          m_err   = 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    cmp(name, act, exp);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      vectors++;
      cmp("wr_ready",   32'(wr_ready),   32'(m_phase == P_LOAD || m_phase == P_CHECK));
      cmp("cpu_hold",   32'(cpu_hold),   32'(m_phase != P_RUN));
      cmp("load_done",  32'(load_done),  32'(m_done));
      cmp("load_error", 32'(load_error), 32'(m_err));
      cmp("load_count", 32'(load_count), 32'(m_words.size()));
      cmp("prog",       32'(prog),       32'((m_phase == P_RUN) ? m_mem[addr] : 10'h000));
    end
  end

  task automatic drive(input logic r, input logic ls, input logic v,
                       input logic [9:0] d, input logic [3:0] a);
    @(negedge clk);
    #1;
    rst = r; load_start = ls; wr_valid = v; wr_data = d; addr = a;
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  initial begin
    // Reset state
    drive(1'b1, 1'b0, 1'b0, 10'h0, 4'h0);
    settle();
    cmp_en = 1'b1;
    lit("rst_cpu_hold",   32'(cpu_hold),   32'd1);
    lit("rst_wr_ready",   32'(wr_ready),   32'd0);
    lit("rst_load_done",  32'(load_done),  32'd0);
    lit("rst_prog",       32'(prog),       32'd0);
    lit("rst_load_count", 32'(load_count), 32'd0);
    lit("rst_load_error", 32'(load_error), 32'd0);

    // Back-to-back load of 0x001..0x010
    drive(1'b0, 1'b1, 1'b0, 10'h0, 4'h3);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b1, 10'(i + 1), 4'h3);
`ifdef LOADER_CHECKSUM_EN
    drive(1'b0, 1'b0, 1'b1, 10'h010, 4'h3);
`endif
    settle();
    lit("seq_load_done",  32'(load_done),  32'd1);
    lit("seq_cpu_hold",   32'(cpu_hold),   32'd0);
    lit("seq_load_count", 32'(load_count), 32'd16);
    lit("seq_prog_a3",    32'(prog),       32'h004);
    drive(1'b0, 1'b0, 1'b1, 10'h155, 4'h3);
    settle();
    lit("seq_done_drop",  32'(load_done),  32'd0);
    lit("seq_run_nowr",   32'(prog),       32'h004);

    // wr_valid toggling: only valid cycles count
    drive(1'b0, 1'b1, 1'b0, 10'h0, 4'h0);
    for (int i = 0; i < 32; i++)
      drive(1'b0, 1'b0, (i % 2) == 0, (i % 2 == 0) ? 10'(i / 2 + 1) : 10'h2AA, 4'h0);
`ifdef LOADER_CHECKSUM_EN
    drive(1'b0, 1'b0, 1'b1, 10'h010, 4'h0);
`endif
    settle();
    lit("tog_load_count", 32'(load_count), 32'd16);
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 1'b0, 1'b0, 10'h0, 4'(a));
      settle();
      lit("tog_prog", 32'(prog), 32'(a + 1));
    end

    // Restart after 7 words, then all 0x3FF
    drive(1'b0, 1'b1, 1'b0, 10'h0, 4'h0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b1, 10'($urandom), 4'h0);
    drive(1'b0, 1'b1, 1'b1, 10'h123, 4'h0);
    settle();
    lit("restart_count", 32'(load_count), 32'd0);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b1, 10'h3FF, 4'h0);
`ifdef LOADER_CHECKSUM_EN
    drive(1'b0, 1'b0, 1'b1, 10'h000, 4'h0);
`endif
    settle();
    lit("restart_full", 32'(load_count), 32'd16);
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 1'b0, 1'b0, 10'h0, 4'(a));
      settle();
      lit("restart_prog", 32'(prog), 32'h3FF);
    end

    // Reset in the middle of a load
    drive(1'b0, 1'b1, 1'b0, 10'h0, 4'h0);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 1'b1, 10'(i + 7), 4'h0);
    drive(1'b1, 1'b1, 1'b1, 10'h0AA, 4'h0);
    settle();
    lit("midrst_hold",  32'(cpu_hold),   32'd1);
    lit("midrst_count", 32'(load_count), 32'd0);
    lit("midrst_ready", 32'(wr_ready),   32'd0);
    for (int a = 0; a < 16; a++) begin
      drive(1'b0, 1'b0, 1'b1, 10'h1FF, 4'(a));
      settle();
      lit("midrst_prog", 32'(prog), 32'd0);
    end

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum parks in ERROR until load_start
    drive(1'b0, 1'b1, 1'b0, 10'h0, 4'h0);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b1, 10'(i + 1), 4'h0);
    drive(1'b0, 1'b0, 1'b1, 10'h011, 4'h0);
    settle();
    lit("chk_error", 32'(load_error), 32'd1);
    lit("chk_hold",  32'(cpu_hold),   32'd1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 10'h010, 4'h2);
    settle();
    lit("chk_error_sticky", 32'(load_error), 32'd1);
    lit("chk_prog_nop",     32'(prog),       32'd0);
    drive(1'b0, 1'b1, 1'b0, 10'h0, 4'h0);
    settle();
    lit("chk_error_clear", 32'(load_error), 32'd0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic       r, ls, v;
      logic [9:0] d;
      r  = ($urandom_range(0, 149) == 0);
      ls = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = 10'($urandom);
`ifdef LOADER_CHECKSUM_EN
      if (m_phase == P_CHECK && $urandom_range(0, 1) == 1) d = words_xor();
`endif
      drive(r, ls, v, d, 4'($urandom));
    end

    drive(1'b0, 1'b0, 1'b0, 10'h0, 4'h0);
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
